// File: rtl/cva6_rom_pkg.sv
// cva6_rom_pkg: shared defaults, slot states, port encoding and address check for the ROM arbiter
package cva6_rom_pkg;
  localparam logic [31:0] ROM_BASE_DEF = 32'h0000_0000;
  localparam int ROM_WORDS_DEF = 256;
  typedef enum logic [1:0] {IDLE, PEND, HOLD} slot_state_e;
  typedef enum logic {PORT_I, PORT_D} port_e;
  // 33-bit compare so a window ending at 4 GiB does not wrap
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] base, input int words);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + 33'(4 * words);
    return (addr[1:0] != 2'b00) || (a < lo) || (a >= hi);
  endfunction
endpackage

// File: rtl/cva6_rom_rsp_slot.sv
// cva6_rom_rsp_slot: one port's response slot (IDLE/PEND/HOLD) with hold register and error flag
module cva6_rom_rsp_slot
  import cva6_rom_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gnt,
  input  logic        err,
  input  logic        rsp_ready,
  input  logic [31:0] rom_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  slot_state_e state_q, state_d;
  logic        err_q;
  logic [31:0] hold_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (gnt) err_q <= err;
      if (state_q == PEND && !rsp_ready) hold_q <= err_q ? '0 : rom_rdata;
    end
  end
  always_comb begin
    state_d   = state_q;
    if (state_q == IDLE) state_d = gnt ? PEND : IDLE;
    else state_d = rsp_ready ? (gnt ? PEND : IDLE) : HOLD;
    rsp_valid = state_q != IDLE;
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = state_q == PEND ? (err_q ? '0 : rom_rdata) : state_q == HOLD ? hold_q : '0;
  end
endmodule

// File: rtl/cva6_rom_arbiter.sv
// cva6_rom_arbiter: two-port (I/D) round-robin arbiter onto a single-cycle boot ROM
module cva6_rom_arbiter
  import cva6_rom_pkg::*;
#(
  parameter logic [31:0] ROM_BASE  = ROM_BASE_DEF,
  parameter int          ROM_WORDS = ROM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] i_rsp_rdata,
  output logic        i_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,
  output logic [9:0]  rom_addr,
  input  logic [31:0] rom_rdata
);
  port_e       last_q;
  logic [9:0]  rom_addr_q;
  logic        i_ok, d_ok, gnt_i, gnt_d, i_err, d_err, legal;
  logic [31:0] gnt_addr;
  always_comb begin
    i_ok     = rst_n && i_req_valid && (!i_rsp_valid || i_rsp_ready);
    d_ok     = rst_n && d_req_valid && (!d_rsp_valid || d_rsp_ready);
    gnt_i    = i_ok && (!d_ok || last_q == PORT_D);
    gnt_d    = d_ok && !gnt_i;
    i_err    = addr_err(i_req_addr, ROM_BASE, ROM_WORDS);
    d_err    = addr_err(d_req_addr, ROM_BASE, ROM_WORDS) || d_req_we;
    legal    = (gnt_i && !i_err) || (gnt_d && !d_err);
    gnt_addr = gnt_i ? i_req_addr : d_req_addr;
    rom_addr = legal ? 10'((gnt_addr - ROM_BASE) >> 2) : rom_addr_q;
    i_req_ready = gnt_i;
    d_req_ready = gnt_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= PORT_D;
      rom_addr_q <= '0;
    end else begin
      rom_addr_q <= rom_addr;
      last_q     <= gnt_i ? PORT_I : gnt_d ? PORT_D : last_q;
    end
  end
  cva6_rom_rsp_slot u_slot_i (
    .clk(clk), .rst_n(rst_n), .gnt(gnt_i), .err(i_err), .rsp_ready(i_rsp_ready),
    .rom_rdata(rom_rdata), .rsp_valid(i_rsp_valid), .rsp_rdata(i_rsp_rdata), .rsp_err(i_rsp_err)
  );
  cva6_rom_rsp_slot u_slot_d (
    .clk(clk), .rst_n(rst_n), .gnt(gnt_d), .err(d_err), .rsp_ready(d_rsp_ready),
    .rom_rdata(rom_rdata), .rsp_valid(d_rsp_valid), .rsp_rdata(d_rsp_rdata), .rsp_err(d_rsp_err)
  );
endmodule

// File: tb/tb_cva6_rom_arbiter.sv
// tb_cva6_rom_arbiter: directed stimulus with per-port expected-response queues and a behavioural ROM
module tb_cva6_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_err;
  logic [31:0] i_req_addr, i_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [31:0] d_req_addr, d_rsp_rdata;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rdata = '0;
  logic [31:0] rom_mem [1024];
  logic [32:0] exp_i [$];
  logic [32:0] exp_d [$];
  logic [9:0]  last_rom;
  int          checks = 0;
  int          errors = 0;

  cva6_rom_arbiter #(.ROM_BASE(32'h0), .ROM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_rdata <= rom_mem[rom_addr];

  function automatic logic bad(input logic [31:0] a, input logic we);
    return (a[1:0] != 2'b00) || (a >= 32'h400) || we;
  endfunction

  function automatic logic [32:0] model(input logic [31:0] a, input logic we);
    return bad(a, we) ? {1'b1, 32'h0} : {1'b0, rom_mem[a[11:2]]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic iv, input logic [31:0] ia, input logic irr,
                     input logic dv, input logic [31:0] da, input logic dwe, input logic drr,
                     input logic ei, input logic ed);
    @(negedge clk);
    i_req_valid = iv; i_req_addr = ia; i_rsp_ready = irr;
    d_req_valid = dv; d_req_addr = da; d_req_we = dwe; d_rsp_ready = drr;
    #1;
    chk("i_req_ready", 32'(i_req_ready), 32'(ei));
    chk("d_req_ready", 32'(d_req_ready), 32'(ed));
    chk("i_rsp_valid", 32'(i_rsp_valid), 32'(exp_i.size() != 0));
    if (exp_i.size() != 0) begin
      chk("i_rsp_rdata", i_rsp_rdata, exp_i[0][31:0]);
      chk("i_rsp_err", 32'(i_rsp_err), 32'(exp_i[0][32]));
      if (irr) void'(exp_i.pop_front());
    end
    chk("d_rsp_valid", 32'(d_rsp_valid), 32'(exp_d.size() != 0));
    if (exp_d.size() != 0) begin
      chk("d_rsp_rdata", d_rsp_rdata, exp_d[0][31:0]);
      chk("d_rsp_err", 32'(d_rsp_err), 32'(exp_d[0][32]));
      if (drr) void'(exp_d.pop_front());
    end
    if (ei) exp_i.push_back(model(ia, 1'b0));
    if (ed) exp_d.push_back(model(da, dwe));
    if (ei && !bad(ia, 1'b0)) last_rom = ia[11:2];
    else if (ed && !bad(da, dwe)) last_rom = da[11:2];
    chk("rom_addr", 32'(rom_addr), 32'(last_rom));
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_req_valid = 1'b1; d_req_valid = 1'b1; i_req_addr = 32'h0; d_req_addr = 32'h0; d_req_we = 1'b0;
    #1;
    chk("rst_i_rsp_valid", 32'(i_rsp_valid), 32'h0);
    chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'h0);
    chk("rst_i_req_ready", 32'(i_req_ready), 32'h0);
    chk("rst_d_req_ready", 32'(d_req_ready), 32'h0);
    chk("rst_i_rsp_rdata", i_rsp_rdata, 32'h0);
    chk("rst_d_rsp_err", 32'(d_rsp_err), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    exp_i.delete();
    exp_d.delete();
    last_rom = '0;
    @(negedge clk);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) rom_mem[k] = 32'hDEAD_0000 | 32'(k);
    for (int k = 3; k < 14; k++) rom_mem[k] = 32'h0000_0013 | (32'(k) << 20);
    rom_mem[0] = 32'h1000_1137;
    rom_mem[1] = 32'h2000_02B7;
    rom_mem[2] = 32'h0010_0313;
    rom_mem[14] = 32'hFCDF_F06F;
    rst_n = 1'b0;
    i_req_valid = 1'b0; i_req_addr = '0; i_rsp_ready = 1'b1;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_rsp_ready = 1'b1;
    last_rom = '0;
    do_reset();
    // single I read
    cyc(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    // ties alternate starting with I after reset
    do_reset();
    cyc(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    // I stalled in HOLD while D proceeds
    cyc(1'b1, 32'h38, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    // error requests leave rom_addr untouched
    cyc(1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h2, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    // back-to-back stream
    for (int k = 0; k < 15; k++) cyc(1'b1, 32'(4 * k), 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    idle();
    // reset while I is holding a response
    cyc(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_reset();
    idle();
    cyc(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
